gate_truth_table_checker: RTL

Sequential checker for the combinational gate labs. It drives every input combination into a gate under test, waits a programmable settle time, and samples the gate's output. Each sample is compared against an expected truth table, and the block reports a mismatch count, the first failing vector and pass/fail. It replaces hand-written `#1 $display` benches with a clocked, self-checking harness that drives the DUT and also receives and checks its response.

---
 rtl/gate_truth_table_checker.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/gate_truth_table_checker.sv
// -----------------------------------------------------------------------------
// gate_truth_table_checker
//
// Clocked, self-checking harness for small combinational gates. It walks
// every input vector 0 .. 2^N_IN-1 into the gate under test. Each vector is
// held for SETTLE cycles and the gate output is sampled on the last cycle of
// the hold. Each sample is compared against the EXPECTED truth table. The
// block reports the mismatch count, the first failing vector and pass/fail.
//
// Parameters:
//   N_IN      number of gate inputs (1..6)
//   SETTLE    cycles each vector is held before sampling (1..15)
//   EXPECTED  expected truth table, bit i = expected output for vector i
//
// Ports:
//   clk               clock, all state on the rising edge
//   rst               asynchronous active-high reset
//   start             begin a run (only honoured while idle)
//   vec               input vector driven to the gate under test
//   dut_y             output of the gate under test
//   busy              high while vectors are being applied
//   done              one-cycle pulse when a run ends
//   pass              last completed run had zero mismatches
//   err_count         mismatches in the last or current run
//   first_fail        index of the first mismatching vector
//   first_fail_valid  first_fail holds a real index
// -----------------------------------------------------------------------------
module gate_truth_table_checker #(
  parameter int                  N_IN     = 2,
  parameter int                  SETTLE   = 1,
  parameter logic [2**N_IN-1:0]  EXPECTED = 4'b1110
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] vec,
  input  logic            dut_y,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail,
  output logic            first_fail_valid
);

  localparam int              EW       = N_IN + 1;
  localparam logic [N_IN-1:0] LAST_VEC = '1;
  localparam logic [3:0]      CNT_LAST = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [EW-1:0]   err_q, err_d;
  logic [N_IN-1:0] ff_q, ff_d;
  logic            ffv_q, ffv_d;
  logic            pass_q, pass_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            mismatch_s;

  // State and result registers; reset discards any partial run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      cnt_q   <= 4'd0;
      err_q   <= '0;
      ff_q    <= '0;
      ffv_q   <= 1'b0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      ffv_q   <= ffv_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic. busy/done are computed one cycle early, so the
  // registered copies line up with the state they describe.
  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    ff_d       = ff_q;
    ffv_d      = ffv_q;
    pass_d     = pass_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    mismatch_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        vec_d = '0;
        if (start) begin
          state_d = ST_RUN;
          cnt_d   = 4'd0;
          err_d   = '0;
          ff_d    = '0;
          ffv_d   = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        busy_d = 1'b1;
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          // Case inequality makes an X/Z output from the gate count as a miss.
          mismatch_s = (dut_y !== EXPECTED[vec_q]);
          if (mismatch_s) begin
            err_d = err_q + EW'(1);
            if (!ffv_q) begin
              ff_d  = vec_q;
              ffv_d = 1'b1;
            end else begin
              ff_d  = ff_q;
            end
          end else begin
            err_d = err_q;
          end

          if (vec_q == LAST_VEC) begin
            // pass includes this final compare because it looks at err_d.
            state_d = ST_FIN;
            vec_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end else begin
            vec_d = vec_q + N_IN'(1);
            cnt_d = 4'd0;
          end
        end
      end

      ST_FIN: begin
        // start is ignored here; a held start re-arms from IDLE next cycle.
        state_d = ST_IDLE;
        vec_d   = '0;
      end

      default: begin
        state_d = ST_IDLE;
        vec_d   = '0;
      end
    endcase
  end

  assign vec              = vec_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail       = ff_q;
  assign first_fail_valid = ffv_q;

endmodule
